// File: rtl/mod3_word_scheduler.sv
// Round-robin front end that feeds W-bit words, MSB first, through one shared
// bit-serial mod-3 residue engine and returns the residue per requester.
module mod3_word_scheduler #(
  parameter int W = 8,
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              ser_valid,
  output logic              ser_data,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [1:0]        rsp_residue,
  output logic              rsp_div3,
  input  logic              rsp_ready,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid may drop without a transfer, ready never waits on a transfer.

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e         state_q;
  logic [W-1:0]   shift_q;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     residue_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] rr_q;
  logic [IDW-1:0] rsp_id_q;
  logic [1:0]     rsp_residue_q;
  logic           rsp_div3_q;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic           take;
  logic [1:0]     residue_d;

  // Encoding 3 cannot occur; it falls into the default arm and acts as 0.
  function automatic logic [1:0] res_step(input logic [1:0] r, input logic b);
    case (r)
      2'd1:    res_step = b ? 2'd0 : 2'd2;
      2'd2:    res_step = b ? 2'd2 : 2'd1;
      default: res_step = b ? 2'd1 : 2'd0;
    endcase
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(rr_q) + i) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign take      = (state_q == S_IDLE) && gnt_found;
  assign residue_d = res_step(residue_q, shift_q[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      residue_q     <= 2'd0;
      id_q          <= '0;
      rr_q          <= '0;
      rsp_id_q      <= '0;
      rsp_residue_q <= 2'd0;
      rsp_div3_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (take) begin
            shift_q   <= req_data[int'(gnt_idx)*W +: W];
            id_q      <= gnt_idx;
            residue_q <= 2'd0;
            cnt_q     <= '0;
            rr_q      <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          residue_q <= residue_d;
          shift_q   <= {shift_q[W-2:0], 1'b0};
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CW'(W-1)) begin
            rsp_id_q      <= id_q;
            rsp_residue_q <= residue_d;
            rsp_div3_q    <= (residue_d == 2'd0);
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ser_valid   = (state_q == S_SHIFT);
  assign ser_data    = shift_q[W-1];
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_id      = rsp_id_q;
  assign rsp_residue = rsp_residue_q;
  assign rsp_div3    = rsp_div3_q;
  assign dbg_state   = state_q;

endmodule
